// File: rtl/pipe_arbiter.sv
// ============================================================================
// pipe_arbiter
// ----------------------------------------------------------------------------
// Purpose
//   Shares one fixed-latency pipelined math unit among NREQ requesters.
//   - A round-robin arbiter issues at most one operand per enabled cycle.
//   - A LATENCY-deep valid/ID tracker runs in lockstep with the unit.
//   - The tracker routes each result back to the requester that issued it.
//   - A stalled response in the output slot freezes the tracker and the unit
//     together through pipe_en.
//
// Handshake semantics (all request and response ports)
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   valid must not depend on ready. ready may depend on valid.
//   Here req_ready depends combinationally on rsp_ready through pipe_en.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]        operand valid per requester
//   req_ready  [NREQ]        accept per requester; one-hot or zero
//   req_data   [NREQ*WIDTH]  operands; requester i at [i*WIDTH +: WIDTH]
//   pipe_en                  enable to every stage of the attached unit
//   pipe_in    [WIDTH]       operand into the unit; 0 when nothing is granted
//   pipe_out   [RWIDTH]      result from the unit
//   rsp_valid  [NREQ]        result valid per requester; one-hot or zero
//   rsp_ready  [NREQ]        result accept per requester
//   rsp_data   [RWIDTH]      shared result bus; equals pipe_out
//   busy                     any tracker stage holds a live operation
//
// Optional build macro: PIPE_ARB_STATS_EN
//   When defined, three free-running observation counters are added.
//   Each counter is 32 bits, resets to 0 and wraps.
//   stat_issued  counts issues.
//   stat_stall   counts cycles with pipe_en=0.
//   stat_bubble  counts enabled cycles with no issue.
// ============================================================================
module pipe_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int RWIDTH  = 32,
    parameter int LATENCY = 3,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic                   pipe_en,
    output logic [WIDTH-1:0]       pipe_in,
    input  logic [RWIDTH-1:0]      pipe_out,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [RWIDTH-1:0]      rsp_data,
    output logic                   busy
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [31:0]            stat_issued,
    output logic [31:0]            stat_stall,
    output logic [31:0]            stat_bubble
`endif
);

    // Tracker: stage 0 is the entry and stage LATENCY-1 is the output slot.
    logic [LATENCY-1:0] vld;
    logic [IDW-1:0]     id [LATENCY];
    logic [IDW-1:0]     ptr;        // last granted requester

    logic               out_vld;
    logic [IDW-1:0]     out_id;
    logic               out_rdy;    // rsp_ready of the output slot's owner
    logic               found;
    logic [IDW-1:0]     grant;
    logic               issue;
    int                 idx;

    assign out_vld  = vld[LATENCY-1];
    assign out_id   = id[LATENCY-1];
    assign busy     = |vld;
    assign rsp_data = pipe_out;

    // Response routing and stall.
    // Only the owner of a valid output slot can stall the pipe.
    // rsp_ready toward any other requester is ignored.
    always_comb begin
        rsp_valid = '0;
        out_rdy   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (out_id == IDW'(k)) begin
                rsp_valid[k] = out_vld;
                out_rdy      = rsp_ready[k];
            end
        end
    end

    assign pipe_en = !(out_vld && !out_rdy);

    // Round-robin search, starting one past the last grant.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    // A grant turns into an issue only while the pipe is moving.
    assign issue = found && pipe_en;

    always_comb begin
        req_ready = '0;
        pipe_in   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (issue && grant == IDW'(k)) begin
                req_ready[k] = 1'b1;
                pipe_in      = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Valid bits and round-robin pointer.
    // Both reset asynchronously, so in-flight work is dropped at once.
    // When enabled, the output slot is either drained or a bubble.
    // In both cases the shift overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ptr <= IDW'(NREQ - 1);
        end else if (pipe_en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
            end
            vld[0] <= issue;
            if (issue) begin
                ptr <= grant;
            end
        end
    end

    // IDs need no reset: vld qualifies every use.
    always_ff @(posedge clk) begin
        if (pipe_en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                id[i] <= id[i-1];
            end
            id[0] <= grant;
        end
    end

`ifdef PIPE_ARB_STATS_EN
    // Observation only; nothing here feeds back into arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
            stat_bubble <= '0;
        end else begin
            if (issue) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (!pipe_en) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (pipe_en && !issue) begin
                stat_bubble <= stat_bubble + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// ============================================================================
// tb_pipe_arbiter
//   Self-checking bench for pipe_arbiter.
//   NREQ=4, LATENCY=3, identity register-chain unit.
//   The reference model is a queue of in-flight operations.
//   Each entry is stamped with the enabled-cycle count at issue, which gives
//   its age in the pipe.
// ============================================================================
module tb_pipe_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int RWIDTH  = 32;
    localparam int LATENCY = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data  = '0;
    logic                  pipe_en;
    logic [WIDTH-1:0]      pipe_in;
    logic [RWIDTH-1:0]     pipe_out;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready = '1;
    logic [RWIDTH-1:0]     rsp_data;
    logic                  busy;
`ifdef PIPE_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stall, stat_bubble;
`endif

    pipe_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .RWIDTH(RWIDTH), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .pipe_en(pipe_en), .pipe_in(pipe_in), .pipe_out(pipe_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
`ifdef PIPE_ARB_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_bubble(stat_bubble)
`endif
    );

    // Attached unit: identity function, LATENCY enabled stages, no reset.
    logic [WIDTH-1:0] unit_r [LATENCY];
    always @(posedge clk) begin
        if (pipe_en) begin
            for (int i = LATENCY - 1; i > 0; i--) unit_r[i] <= unit_r[i-1];
            unit_r[0] <= pipe_in;
        end
    end
    assign pipe_out = unit_r[LATENCY-1];

    // ---------------- scoreboard / reference model ----------------
    logic [RWIDTH-1:0] exp_q[$];   // expected results, in issue order
    int                exp_id[$];  // owning requester
    int                exp_t[$];   // enabled-cycle stamp at issue
    int                en_cnt;     // enabled edges seen since reset
    int                last_g;     // last granted requester

    int checks = 0;
    int passes = 0;

    // Values seen at the most recent sample.
    logic [NREQ-1:0]   obs_rr, obs_rv;
    logic              obs_en, obs_busy;
    logic [RWIDTH-1:0] obs_rd;

    task automatic model_clear();
        exp_q.delete(); exp_id.delete(); exp_t.delete();
        en_cnt = 0;
        last_g = NREQ - 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] d);
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    // One clock cycle. Inputs are already driven.
    // Outputs are sampled at negedge and compared with the model.
    // The model then advances on the posedge.
    task automatic step();
        logic              head_out, e_en, found;
        int                g, c;
        logic [NREQ-1:0]   e_rr, e_rv;
        logic [WIDTH-1:0]  e_pin;
        @(negedge clk);
        head_out = 1'b0;
        if (exp_q.size() > 0) head_out = ((en_cnt - exp_t[0]) == LATENCY - 1);
        e_rv = '0;
        e_en = 1'b1;
        if (head_out) begin
            e_rv[exp_id[0]] = 1'b1;
            e_en = rsp_ready[exp_id[0]];
        end
        found = 1'b0; g = 0;
        for (int i = 1; i <= NREQ; i++) begin
            c = (last_g + i) % NREQ;
            if (!found && req_valid[c]) begin found = 1'b1; g = c; end
        end
        e_rr = '0; e_pin = '0;
        if (found && e_en) begin
            e_rr[g] = 1'b1;
            e_pin = req_data[g*WIDTH +: WIDTH];
        end

        checks++;
        if (pipe_en !== e_en) $display("FAIL pipe_en: got %b expected %b @%0t", pipe_en, e_en, $time);
        else passes++;
        checks++;
        if (req_ready !== e_rr) $display("FAIL req_ready: got %b expected %b @%0t", req_ready, e_rr, $time);
        else passes++;
        checks++;
        if (pipe_in !== e_pin) $display("FAIL pipe_in: got %h expected %h @%0t", pipe_in, e_pin, $time);
        else passes++;
        checks++;
        if (rsp_valid !== e_rv) $display("FAIL rsp_valid: got %b expected %b @%0t", rsp_valid, e_rv, $time);
        else passes++;
        checks++;
        if (busy !== (exp_q.size() > 0)) $display("FAIL busy: got %b expected %b @%0t", busy, exp_q.size() > 0, $time);
        else passes++;
        if (head_out) begin
            checks++;
            if (rsp_data !== exp_q[0]) $display("FAIL rsp_data: got %h expected %h @%0t", rsp_data, exp_q[0], $time);
            else passes++;
        end
        obs_rr = req_ready; obs_rv = rsp_valid; obs_en = pipe_en;
        obs_busy = busy; obs_rd = rsp_data;

        @(posedge clk);
        if (e_en) begin
            if (head_out) begin
                void'(exp_q.pop_front()); void'(exp_id.pop_front()); void'(exp_t.pop_front());
            end
            en_cnt++;
            if (found) begin
                exp_q.push_back(req_data[g*WIDTH +: WIDTH]);
                exp_id.push_back(g);
                exp_t.push_back(en_cnt);
                last_g = g;
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++;
        if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passes++;
        checks++;
        if (pipe_en !== 1'b1) $display("FAIL reset_pipe_en: got %b expected 1", pipe_en); else passes++;
`ifdef PIPE_ARB_STATS_EN
        checks++;
        if (stat_issued !== 0 || stat_stall !== 0 || stat_bubble !== 0)
            $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", stat_issued, stat_stall, stat_bubble);
        else passes++;
`endif
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_data(2, 32'h5);
        req_valid = 4'b0100;
        step();
        checks++;
        if (obs_rr !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", obs_rr); else passes++;
        req_valid = '0;
        for (int t = 1; t <= 4; t++) begin
            step();
            checks++;
            if (obs_busy !== (t <= 3)) $display("FAIL single_busy t%0d: got %b expected %b", t, obs_busy, t <= 3);
            else passes++;
            if (t == 3) begin
                checks++;
                if (obs_rv !== 4'b0100 || obs_rd !== 32'h5)
                    $display("FAIL single_rsp: got %b/%h expected 0100/00000005", obs_rv, obs_rd);
                else passes++;
            end
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] want;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h10 + i);
        req_valid = 4'hF;
        for (int t = 0; t < 8; t++) begin
            step();
            if (t < 6) begin
                want = '0; want[t % NREQ] = 1'b1;
                checks++;
                if (obs_rr !== want) $display("FAIL fair_grant t%0d: got %b expected %b", t, obs_rr, want);
                else passes++;
            end
            if (t >= 3) begin
                checks++;
                if (obs_rd !== 32'h10 + ((t - 3) % NREQ))
                    $display("FAIL fair_rsp t%0d: got %h expected %h", t, obs_rd, 32'h10 + ((t - 3) % NREQ));
                else passes++;
            end
        end
        req_valid = '0;
    endtask

    // Requester 1's first result reaches the output slot at t=4.
    task automatic bp_drive(input int t);
        rsp_ready = (t >= 4 && t < 8) ? 4'b1101 : 4'hF;
    endtask

    task automatic test_backpressure();
        int stalls;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h10 + i);
        req_valid = 4'hF;
        stalls = 0;
        for (int t = 0; t < 16; t++) begin
            bp_drive(t);
            step();
            if (!obs_en) stalls++;
            if (t == 8) begin
                checks++;
                if (obs_rv !== 4'b0010 || obs_rd !== 32'h11)
                    $display("FAIL bp_release: got %b/%h expected 0010/00000011", obs_rv, obs_rd);
                else passes++;
            end
            if (t == 9) begin
                checks++;
                if (obs_rd !== 32'h12) $display("FAIL bp_resume: got %h expected 00000012", obs_rd);
                else passes++;
            end
        end
        checks++;
        if (stalls != 4) $display("FAIL bp_stall_count: got %0d expected 4", stalls); else passes++;
        req_valid = '0; rsp_ready = '1;
    endtask

    task automatic test_bubbles();
        do_reset();
        for (int t = 0; t < 6; t++) begin
            req_valid = (t == 0 || t == 2) ? 4'b1000 : 4'b0000;
            set_data(3, (t == 0) ? 32'hA : 32'hB);
            step();
            if (t == 3 || t == 5) begin
                checks++;
                if (obs_rv !== 4'b1000 || obs_rd !== ((t == 3) ? 32'hA : 32'hB))
                    $display("FAIL bubble_rsp t%0d: got %b/%h", t, obs_rv, obs_rd);
                else passes++;
            end
            if (t == 4) begin
                checks++;
                if (obs_rv !== 4'b0000) $display("FAIL bubble_gap: got %b expected 0000", obs_rv); else passes++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h20 + i);
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== '0) $display("FAIL midrst_rsp_valid: got %b expected 0", rsp_valid); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passes++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        step();
        checks++;
        if (obs_rr !== 4'b0001) $display("FAIL midrst_first_grant: got %b expected 0001", obs_rr); else passes++;
        req_valid = '0;
        for (int t = 0; t < 6; t++) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_data(i, $urandom);
            for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0; rsp_ready = '1;
        for (int t = 0; t < 8; t++) step();
        checks++;
        if (exp_q.size() != 0) $display("FAIL random_drain: got %0d left expected 0", exp_q.size()); else passes++;
    endtask

`ifdef PIPE_ARB_STATS_EN
    task automatic test_stats();
        int pulses;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h10 + i);
        req_valid = 4'hF;
        pulses = 0;
        for (int t = 0; t < 20; t++) begin
            bp_drive(t);
            step();
            if (obs_rr != '0) pulses++;
        end
        checks++;
        if (stat_stall !== 32'd4) $display("FAIL stat_stall: got %0d expected 4", stat_stall); else passes++;
        checks++;
        if (stat_issued !== 32'(pulses)) $display("FAIL stat_issued: got %0d expected %0d", stat_issued, pulses);
        else passes++;
        checks++;
        if (stat_bubble !== 32'd0) $display("FAIL stat_bubble: got %0d expected 0", stat_bubble); else passes++;
        req_valid = '0; rsp_ready = '1;
    endtask
`endif

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and final report ----------------
    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_random();
`ifdef PIPE_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
